udp_stream_arbiter: RTL and testbench



---
 rtl/udp_stream_arbiter.sv | 148 ++++++++++++++
 tb/tb_udp_stream_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_stream_arbiter.sv
// N-channel packet arbiter for the UDP transmit path: merges CH_NUM AXI-Stream sources with header sideband.
// Define UDP_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
module udp_stream_arbiter #(
    parameter  int CH_NUM = 4,
    parameter  int DATA_W = 32,
    localparam int KEEP_W = DATA_W / 8,
    localparam int ID_W   = $clog2(CH_NUM)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [CH_NUM*48-1:0]       s_hdr_mac_dest_i,
    input  logic [CH_NUM*48-1:0]       s_hdr_mac_src_i,
    input  logic [CH_NUM*32-1:0]       s_hdr_ip_dest_i,
    input  logic [CH_NUM*32-1:0]       s_hdr_ip_src_i,
    input  logic [CH_NUM*16-1:0]       s_hdr_port_dest_i,
    input  logic [CH_NUM*16-1:0]       s_hdr_port_src_i,
    input  logic [CH_NUM*DATA_W-1:0]   s_tdata_i,
    input  logic [CH_NUM*KEEP_W-1:0]   s_tkeep_i,
    input  logic [CH_NUM-1:0]          s_tvld_i,
    input  logic [CH_NUM-1:0]          s_tlast_i,
    output logic [CH_NUM-1:0]          s_trdy_o,
    output logic [47:0]                m_hdr_mac_dest_o,
    output logic [47:0]                m_hdr_mac_src_o,
    output logic [31:0]                m_hdr_ip_dest_o,
    output logic [31:0]                m_hdr_ip_src_o,
    output logic [15:0]                m_hdr_port_dest_o,
    output logic [15:0]                m_hdr_port_src_o,
    output logic                       m_hdr_vld_o,
    output logic [ID_W-1:0]            m_tid_o,
    output logic [DATA_W-1:0]          m_tdata_o,
    output logic [KEEP_W-1:0]          m_tkeep_o,
    output logic                       m_tvld_o,
    output logic                       m_tlast_o,
    input  logic                       m_trdy_i
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant, grant_nxt, pick;
    logic [CH_NUM-1:0] first;
    logic              adv, acc, any_req, found;
    int                g;

    assign g       = int'(grant);
    assign adv     = !m_tvld_o || m_trdy_i;
    assign any_req = |s_tvld_i;
    assign acc     = (state == LOCK) && adv && s_tvld_i[g];

    always_comb begin
        s_trdy_o = '0;
        if (state == LOCK && adv) s_trdy_o[g] = 1'b1;
    end

    // Round-robin starts the search just after the current grant, so the
    // channel that just finished is considered last.
    always_comb begin
        pick  = grant;
        found = 1'b0;
`ifdef UDP_ARB_RR_EN
        for (int i = 1; i <= CH_NUM; i++) begin
            if (!found && s_tvld_i[(g + i) % CH_NUM]) begin
                pick  = ID_W'((g + i) % CH_NUM);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < CH_NUM; i++) begin
            if (!found && s_tvld_i[i]) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                // Only a completed packet releases the grant; gaps do not.
                if (acc && s_tlast_i[g]) begin
                    if (any_req) grant_nxt = pick;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  first    <= '1;
        else if (acc)  first[g] <= s_tlast_i[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tvld_o          <= 1'b0;
            m_hdr_vld_o       <= 1'b0;
            m_tdata_o         <= '0;
            m_tkeep_o         <= '0;
            m_tlast_o         <= 1'b0;
            m_tid_o           <= '0;
            m_hdr_mac_dest_o  <= '0;
            m_hdr_mac_src_o   <= '0;
            m_hdr_ip_dest_o   <= '0;
            m_hdr_ip_src_o    <= '0;
            m_hdr_port_dest_o <= '0;
            m_hdr_port_src_o  <= '0;
        end else if (adv) begin
            m_tvld_o    <= acc;
            m_hdr_vld_o <= acc && first[g];
            if (acc) begin
                m_tdata_o <= s_tdata_i[g*DATA_W +: DATA_W];
                m_tkeep_o <= s_tkeep_i[g*KEEP_W +: KEEP_W];
                m_tlast_o <= s_tlast_i[g];
                m_tid_o   <= grant;
            end
            // Headers are captured on the first beat and held for the packet.
            if (acc && first[g]) begin
                m_hdr_mac_dest_o  <= s_hdr_mac_dest_i[g*48 +: 48];
                m_hdr_mac_src_o   <= s_hdr_mac_src_i[g*48 +: 48];
                m_hdr_ip_dest_o   <= s_hdr_ip_dest_i[g*32 +: 32];
                m_hdr_ip_src_o    <= s_hdr_ip_src_i[g*32 +: 32];
                m_hdr_port_dest_o <= s_hdr_port_dest_i[g*16 +: 16];
                m_hdr_port_src_o  <= s_hdr_port_src_i[g*16 +: 16];
            end
        end
    end

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Testbench for udp_stream_arbiter: directed phases plus random traffic checked cycle by cycle
// against a queue-based reference model; honours UDP_ARB_RR_EN like the design.
module tb_udp_stream_arbiter;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = $clog2(CH);

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CH*48-1:0] mac_d, mac_s;
    logic [CH*32-1:0] ip_d, ip_s;
    logic [CH*16-1:0] pt_d, pt_s;
    logic [CH*DW-1:0] tdata;
    logic [CH*KW-1:0] tkeep;
    logic [CH-1:0]    tvld, tlast, trdy;
    logic [47:0] o_mac_d, o_mac_s;
    logic [31:0] o_ip_d, o_ip_s;
    logic [15:0] o_pt_d, o_pt_s;
    logic        o_hv, o_tvld, o_tlast;
    logic [IW-1:0] o_tid;
    logic [DW-1:0] o_tdata;
    logic [KW-1:0] o_tkeep;
    logic          m_trdy;

    udp_stream_arbiter #(.CH_NUM(CH), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_hdr_mac_dest_i(mac_d), .s_hdr_mac_src_i(mac_s),
        .s_hdr_ip_dest_i(ip_d), .s_hdr_ip_src_i(ip_s),
        .s_hdr_port_dest_i(pt_d), .s_hdr_port_src_i(pt_s),
        .s_tdata_i(tdata), .s_tkeep_i(tkeep), .s_tvld_i(tvld), .s_tlast_i(tlast),
        .s_trdy_o(trdy),
        .m_hdr_mac_dest_o(o_mac_d), .m_hdr_mac_src_o(o_mac_s),
        .m_hdr_ip_dest_o(o_ip_d), .m_hdr_ip_src_o(o_ip_s),
        .m_hdr_port_dest_o(o_pt_d), .m_hdr_port_src_o(o_pt_s),
        .m_hdr_vld_o(o_hv), .m_tid_o(o_tid), .m_tdata_o(o_tdata), .m_tkeep_o(o_tkeep),
        .m_tvld_o(o_tvld), .m_tlast_o(o_tlast), .m_trdy_i(m_trdy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // source side
    beat_t q[CH][$];
    int    gap_pct[CH];
    int    mtrdy_pct = 100;
    logic  mtq[$];
    int    acc_ch = -1;
    int    nacc = 0;
    int    obs_beats = 0;
    int    obs_hdr = 0;

    // reference model of the registered output and the arbitration decision
    logic          m_busy;
    int            m_g;
    logic [CH-1:0] m_first;
    logic          m_vld, m_hv, m_last;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [IW-1:0] m_tid;
    logic [47:0]   m_mac_d, m_mac_s;
    logic [31:0]   m_ip_d, m_ip_s;
    logic [15:0]   m_pt_d, m_pt_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [CH-1:0] req, input int base);
        int r;
        logic f;
        r = base;
        f = 1'b0;
`ifdef UDP_ARB_RR_EN
        for (int i = 1; i <= CH; i++)
            if (!f && req[(base + i) % CH]) begin r = (base + i) % CH; f = 1'b1; end
`else
        for (int i = 0; i < CH; i++)
            if (!f && req[i]) begin r = i; f = 1'b1; end
`endif
        return r;
    endfunction

    task automatic new_hdr(input int c);
        mac_d[c*48 +: 48] = {16'($urandom), 32'($urandom)};
        mac_s[c*48 +: 48] = {16'($urandom), 32'($urandom)};
        ip_d[c*32 +: 32]  = $urandom;
        ip_s[c*32 +: 32]  = $urandom;
        pt_d[c*16 +: 16]  = 16'($urandom);
        pt_s[c*16 +: 16]  = 16'($urandom);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_g = 0; m_first = '1;
        m_vld = 1'b0; m_hv = 1'b0; m_last = 1'b0; m_data = '0; m_keep = '0; m_tid = '0;
        m_mac_d = '0; m_mac_s = '0; m_ip_d = '0; m_ip_s = '0; m_pt_d = '0; m_pt_s = '0;
    endtask

    task automatic check_outputs();
        chk("tvld", o_tvld, m_vld);
        chk("hdr_vld", o_hv, m_hv);
        chk("tdata", o_tdata, m_data);
        chk("tkeep", o_tkeep, m_keep);
        chk("tlast", o_tlast, m_last);
        chk("tid", o_tid, m_tid);
        chk("mac_dest", o_mac_d, m_mac_d);
        chk("mac_src", o_mac_s, m_mac_s);
        chk("ip_dest", o_ip_d, m_ip_d);
        chk("ip_src", o_ip_s, m_ip_s);
        chk("port_dest", o_pt_d, m_pt_d);
        chk("port_src", o_pt_s, m_pt_s);
    endtask

    // Predict what the coming rising edge does, from the inputs now driven.
    task automatic step();
        logic adv, acc, lst;
        logic [CH-1:0] exp_trdy;
        adv = !m_vld || m_trdy;
        exp_trdy = '0;
        if (m_busy && adv) exp_trdy[m_g] = 1'b1;
        chk("s_trdy", trdy, exp_trdy);
        acc = m_busy && adv && tvld[m_g];
        lst = tlast[m_g];
        if (adv) begin
            m_vld = acc;
            m_hv  = acc && m_first[m_g];
            if (acc) begin
                m_data = tdata[m_g*DW +: DW];
                m_keep = tkeep[m_g*KW +: KW];
                m_last = lst;
                m_tid  = IW'(m_g);
            end
            if (acc && m_first[m_g]) begin
                m_mac_d = mac_d[m_g*48 +: 48]; m_mac_s = mac_s[m_g*48 +: 48];
                m_ip_d  = ip_d[m_g*32 +: 32];  m_ip_s  = ip_s[m_g*32 +: 32];
                m_pt_d  = pt_d[m_g*16 +: 16];  m_pt_s  = pt_s[m_g*16 +: 16];
            end
        end
        if (acc) begin
            m_first[m_g] = lst;
            acc_ch = m_g;
            nacc++;
        end
        if (!m_busy) begin
            if (|tvld) begin m_g = pick(tvld, m_g); m_busy = 1'b1; end
        end else if (acc && lst) begin
            if (|tvld) m_g = pick(tvld, m_g);
            else       m_busy = 1'b0;
        end
    endtask

    task automatic cycle();
        beat_t b;
        @(negedge clk);
        check_outputs();
        if (acc_ch >= 0) begin
            b = q[acc_ch].pop_front();
            tvld[acc_ch] = 1'b0;
            if (b.l) new_hdr(acc_ch);
            acc_ch = -1;
        end
        if (mtq.size() > 0) m_trdy = mtq.pop_front();
        else                m_trdy = ($urandom_range(99) < mtrdy_pct);
        obs_beats += int'(o_tvld && m_trdy);
        obs_hdr   += int'(o_tvld && o_hv && m_trdy);
        for (int c = 0; c < CH; c++) begin
            if (!tvld[c] && q[c].size() > 0 && $urandom_range(99) >= gap_pct[c]) begin
                tvld[c] = 1'b1;
                tdata[c*DW +: DW] = q[c][0].d;
                tkeep[c*KW +: KW] = q[c][0].k;
                tlast[c] = q[c][0].l;
            end
        end
        #1;
        step();
    endtask

    task automatic add_pkt(input int c, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = $urandom;
            b.k = KW'($urandom_range(1, (1 << KW) - 1));
            b.l = (i == n - 1);
            q[c].push_back(b);
        end
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        reset_n = 1'b0;
        tvld = '0;
        tlast = '0;
        for (int c = 0; c < CH; c++) begin q[c].delete(); gap_pct[c] = 0; end
        mtq.delete();
        acc_ch = -1;
        nacc = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (cyc) begin
            @(negedge clk);
            check_outputs();
            chk("trdy_in_reset", trdy, '0);
        end
        reset_n = 1'b1;
        obs_beats = 0;
        obs_hdr = 0;
    endtask

    initial begin
        beat_t b;
        m_trdy = 1'b0;
        tvld = '0; tlast = '0; tdata = '0; tkeep = '0;
        for (int c = 0; c < CH; c++) new_hdr(c);
        model_reset();

        // reset release, then idle: outputs and s_trdy stay 0
        do_reset(2);
        mtrdy_pct = 100;
        repeat (10) cycle();

        // channel 2 alone, three beats 0x11/0x22/0x33
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            b.d = DW'(32'h11 * (i + 1));
            b.k = 4'hF;
            b.l = (i == 2);
            q[2].push_back(b);
        end
        repeat (8) cycle();
        chk("ch2_beats", obs_beats, 3);
        chk("ch2_hdr_cnt", obs_hdr, 1);

        // channels 0, 1, 3 each with back-to-back 2-beat packets
        do_reset(1);
        for (int p = 0; p < 4; p++) begin add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2); end
        repeat (30) cycle();

        // downstream stall 1,0,0,1 inside a 4-beat packet
        do_reset(1);
        add_pkt(1, 4);
        repeat (3) cycle();
        mtq.push_back(1'b1); mtq.push_back(1'b0); mtq.push_back(1'b0); mtq.push_back(1'b1);
        repeat (10) cycle();
        chk("stall_beats", obs_beats, 4);

        // channel 1 gaps mid-packet while channel 0 requests
        do_reset(1);
        add_pkt(1, 4);
        repeat (3) cycle();
        gap_pct[1] = 100;
        add_pkt(0, 2);
        repeat (3) cycle();
        gap_pct[1] = 0;
        repeat (12) cycle();
        chk("gap_beats", obs_beats, 6);

        // reset during beat 2 of a 4-beat packet, then a fresh packet
        do_reset(1);
        add_pkt(0, 4);
        for (int i = 0; i < 20 && nacc < 2; i++) cycle();
        chk("reset_wait", 64'(nacc >= 2), 1);
        do_reset(2);
        new_hdr(3);
        add_pkt(3, 3);
        repeat (8) cycle();
        chk("post_reset_hdr", obs_hdr, 1);

        // random traffic with gaps and back-pressure
        do_reset(1);
        for (int c = 0; c < CH; c++) begin
            gap_pct[c] = $urandom_range(0, 50);
            for (int p = 0; p < 12; p++) add_pkt(c, $urandom_range(1, 5));
        end
        mtrdy_pct = 70;
        repeat (1500) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
